// File: rtl/sdram_arbiter_pkg.sv
// Shared definitions for the two-cache SDRAM arbiter.
package sdram_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 16;
  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_BURST_LEN  = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 6;

  // Arbiter ownership states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2,
    ST_TURN = 2'd3
  } arb_state_e;

endpackage

// File: rtl/sdram_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie, choose the port not served last.
module rr_pick2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       sel_c,
  output logic       valid_c
);

  // Select cache 1 when it is the only requester or when cache 0 was served last
  always_comb begin
    valid_c = |req_i;
    sel_c   = req_i[1];
    if (&req_i) sel_c = ~last_i;
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Grants the single SDRAM port to one of two caches with round-robin and a per-grant strobe limit.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_c0,
  input  logic [ADDR_WIDTH-1:0] Address_c0,
  input  logic                  wr_rd_c0,
  input  logic                  mstrb_c0,
  input  logic [DATA_WIDTH-1:0] din_sdram_c0,
  output logic                  gnt_c0,
  output logic [DATA_WIDTH-1:0] DOut_sdram_c0,
  input  logic                  req_c1,
  input  logic [ADDR_WIDTH-1:0] Address_c1,
  input  logic                  wr_rd_c1,
  input  logic                  mstrb_c1,
  input  logic [DATA_WIDTH-1:0] din_sdram_c1,
  output logic                  gnt_c1,
  output logic [DATA_WIDTH-1:0] DOut_sdram_c1,
  output logic [ADDR_WIDTH-1:0] Address_sdram,
  output logic                  wr_rd_sdram,
  output logic                  mstrb_sdram,
  output logic [DATA_WIDTH-1:0] din_sdram,
  input  logic [DATA_WIDTH-1:0] DOut_sdram,
  output logic [CNT_WIDTH-1:0]  strb_cnt,
  output logic                  err_c0,
  output logic                  err_c1
);

  arb_state_e           state_q, state_d;
  logic                 last_q, last_d;
  logic [CNT_WIDTH-1:0] strb_cnt_q, strb_cnt_d;
  logic                 err_c0_q, err_c0_d;
  logic                 err_c1_q, err_c1_d;
  logic                 gnt_c0_q, gnt_c0_d;
  logic                 gnt_c1_q, gnt_c1_d;

  logic own0, own1, owner_mstrb, cnt_full;
  logic pick_sel, pick_valid;

  assign own0     = (state_q == ST_G0);
  assign own1     = (state_q == ST_G1);
  assign cnt_full = (strb_cnt_q == CNT_WIDTH'(BURST_LEN));

  rr_pick2 u_pick (
    .req_i   ({req_c1, req_c0}),
    .last_i  (last_q),
    .sel_c   (pick_sel),
    .valid_c (pick_valid)
  );

  // Zero-latency mux of the owner's signals; everything reads 0 without a grant
  always_comb begin
    Address_sdram = '0;
    wr_rd_sdram   = 1'b0;
    din_sdram     = '0;
    owner_mstrb   = 1'b0;
    DOut_sdram_c0 = '0;
    DOut_sdram_c1 = '0;
    if (own0) begin
      Address_sdram = Address_c0;
      wr_rd_sdram   = wr_rd_c0;
      din_sdram     = din_sdram_c0;
      owner_mstrb   = mstrb_c0;
      DOut_sdram_c0 = DOut_sdram;
    end else if (own1) begin
      Address_sdram = Address_c1;
      wr_rd_sdram   = wr_rd_c1;
      din_sdram     = din_sdram_c1;
      owner_mstrb   = mstrb_c1;
      DOut_sdram_c1 = DOut_sdram;
    end
  end

  // Owner strobes pass only while the burst budget remains
  assign mstrb_sdram = owner_mstrb & ~cnt_full;

  // Next-state, pointer, strobe counter and sticky error flags
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    strb_cnt_d = strb_cnt_q;
    err_c0_d   = err_c0_q;
    err_c1_d   = err_c1_q;

    if (mstrb_sdram) strb_cnt_d = strb_cnt_q + CNT_WIDTH'(1);
    if (mstrb_c0 && (!own0 || cnt_full)) err_c0_d = 1'b1;
    if (mstrb_c1 && (!own1 || cnt_full)) err_c1_d = 1'b1;

    case (state_q)
      ST_IDLE: if (pick_valid) state_d = pick_sel ? ST_G1 : ST_G0;
      ST_G0: if (!req_c0) begin
        state_d    = ST_TURN;
        last_d     = 1'b0;
        strb_cnt_d = '0;
      end
      ST_G1: if (!req_c1) begin
        state_d    = ST_TURN;
        last_d     = 1'b1;
        strb_cnt_d = '0;
      end
      ST_TURN: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    gnt_c0_d = (state_d == ST_G0);
    gnt_c1_d = (state_d == ST_G1);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      strb_cnt_q <= '0;
      err_c0_q   <= 1'b0;
      err_c1_q   <= 1'b0;
      gnt_c0_q   <= 1'b0;
      gnt_c1_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      strb_cnt_q <= strb_cnt_d;
      err_c0_q   <= err_c0_d;
      err_c1_q   <= err_c1_d;
      gnt_c0_q   <= gnt_c0_d;
      gnt_c1_q   <= gnt_c1_d;
    end
  end

  assign gnt_c0   = gnt_c0_q;
  assign gnt_c1   = gnt_c1_q;
  assign strb_cnt = strb_cnt_q;
  assign err_c0   = err_c0_q;
  assign err_c1   = err_c1_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_sdram_arbiter;

  localparam int unsigned AW    = 16;
  localparam int unsigned DW    = 8;
  localparam int unsigned BURST = 32;
  localparam int unsigned CW    = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_c0 = 0, req_c1 = 0;
  logic [AW-1:0] Address_c0 = '0, Address_c1 = '0;
  logic          wr_rd_c0 = 0, wr_rd_c1 = 0;
  logic          mstrb_c0 = 0, mstrb_c1 = 0;
  logic [DW-1:0] din_sdram_c0 = '0, din_sdram_c1 = '0;
  logic [DW-1:0] DOut_sdram = '0;
  logic          gnt_c0, gnt_c1;
  logic [DW-1:0] DOut_sdram_c0, DOut_sdram_c1;
  logic [AW-1:0] Address_sdram;
  logic          wr_rd_sdram, mstrb_sdram;
  logic [DW-1:0] din_sdram;
  logic [CW-1:0] strb_cnt;
  logic          err_c0, err_c1;

  int checks = 0;
  int failures = 0;

  sdram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_LEN(BURST), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_c0(req_c0), .Address_c0(Address_c0), .wr_rd_c0(wr_rd_c0), .mstrb_c0(mstrb_c0),
    .din_sdram_c0(din_sdram_c0), .gnt_c0(gnt_c0), .DOut_sdram_c0(DOut_sdram_c0),
    .req_c1(req_c1), .Address_c1(Address_c1), .wr_rd_c1(wr_rd_c1), .mstrb_c1(mstrb_c1),
    .din_sdram_c1(din_sdram_c1), .gnt_c1(gnt_c1), .DOut_sdram_c1(DOut_sdram_c1),
    .Address_sdram(Address_sdram), .wr_rd_sdram(wr_rd_sdram), .mstrb_sdram(mstrb_sdram),
    .din_sdram(din_sdram), .DOut_sdram(DOut_sdram), .strb_cnt(strb_cnt),
    .err_c0(err_c0), .err_c1(err_c1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: who owns the port, whether a dead cycle is pending, strobes used
  int m_owner = -1;
  bit m_turn  = 1'b0;
  bit m_last  = 1'b1;
  int m_cnt   = 0;
  bit m_err0  = 1'b0;
  bit m_err1  = 1'b0;
  bit m_live  = 1'b0;

  always @(posedge clk) begin : model
    int own;
    bit turn, last, e0, e1, oreq, ostrb;
    int cnt;
    own = m_owner; turn = m_turn; last = m_last; cnt = m_cnt; e0 = m_err0; e1 = m_err1;
    if (!rst) begin
      own = -1; turn = 1'b0; last = 1'b1; cnt = 0; e0 = 1'b0; e1 = 1'b0;
    end else begin
      if (mstrb_c0 && (own != 0 || cnt == BURST)) e0 = 1'b1;
      if (mstrb_c1 && (own != 1 || cnt == BURST)) e1 = 1'b1;
      ostrb = (own == 0) ? mstrb_c0 : (own == 1) ? mstrb_c1 : 1'b0;
      oreq  = (own == 0) ? req_c0   : (own == 1) ? req_c1   : 1'b0;
      if (ostrb && cnt < BURST) cnt = cnt + 1;
      if (turn) turn = 1'b0;
      else if (own < 0) begin
        if (req_c0 && req_c1) own = last ? 0 : 1;
        else if (req_c0)      own = 0;
        else if (req_c1)      own = 1;
      end else if (!oreq) begin
        last = (own == 1); own = -1; turn = 1'b1; cnt = 0;
      end
    end
    m_owner <= own; m_turn <= turn; m_last <= last; m_cnt <= cnt;
    m_err0 <= e0; m_err1 <= e1; m_live <= 1'b1;
  end

  // Compare every output against the model mid-cycle
  always @(negedge clk) begin
    if (m_live) begin
      chk("m_gnt_c0", 32'(gnt_c0), 32'(m_owner == 0));
      chk("m_gnt_c1", 32'(gnt_c1), 32'(m_owner == 1));
      chk("m_addr", 32'(Address_sdram),
          32'((m_owner == 0) ? Address_c0 : (m_owner == 1) ? Address_c1 : '0));
      chk("m_wr_rd", 32'(wr_rd_sdram),
          32'((m_owner == 0) ? wr_rd_c0 : (m_owner == 1) ? wr_rd_c1 : 1'b0));
      chk("m_din", 32'(din_sdram),
          32'((m_owner == 0) ? din_sdram_c0 : (m_owner == 1) ? din_sdram_c1 : '0));
      chk("m_mstrb", 32'(mstrb_sdram),
          32'(m_cnt < BURST && ((m_owner == 0 && mstrb_c0) || (m_owner == 1 && mstrb_c1))));
      chk("m_dout_c0", 32'(DOut_sdram_c0), 32'((m_owner == 0) ? DOut_sdram : '0));
      chk("m_dout_c1", 32'(DOut_sdram_c1), 32'((m_owner == 1) ? DOut_sdram : '0));
      chk("m_strb_cnt", 32'(strb_cnt), 32'(m_cnt));
      chk("m_err_c0", 32'(err_c0), 32'(m_err0));
      chk("m_err_c1", 32'(err_c1), 32'(m_err1));
    end
  end

  initial begin
    // Reset held with c0 requesting: nothing granted
    req_c0 = 1'b1;
    repeat (3) step();
    chk("rst_gnt_c0", 32'(gnt_c0), 32'd0);
    chk("rst_addr", 32'(Address_sdram), 32'd0);
    chk("rst_err", 32'({err_c1, err_c0}), 32'd0);
    rst = 1'b1;
    step();
    chk("post_rst_gnt_c0", 32'(gnt_c0), 32'd1);

    // Single-owner passthrough, 32 strobes
    Address_c0 = 16'h1A40; wr_rd_c0 = 1'b0; DOut_sdram = 8'h5C;
    for (int i = 0; i < 32; i++) begin
      mstrb_c0 = 1'b1;
      #1;
      chk("pass_strobe", 32'(mstrb_sdram), 32'd1);
      chk("pass_addr", 32'(Address_sdram), 32'h1A40);
      step();
    end
    mstrb_c0 = 1'b0;
    #1;
    chk("pass_cnt", 32'(strb_cnt), 32'd32);
    chk("pass_dout_c0", 32'(DOut_sdram_c0), 32'h5C);
    chk("pass_dout_c1", 32'(DOut_sdram_c1), 32'd0);

    // Non-owner strobe
    mstrb_c1 = 1'b1;
    #1;
    chk("nonown_blocked", 32'(mstrb_sdram), 32'd0);
    step();
    mstrb_c1 = 1'b0;
    #1;
    chk("nonown_err_c1", 32'(err_c1), 32'd1);
    chk("nonown_err_c0", 32'(err_c0), 32'd0);

    // Release while c1 raises req: one TURN, one IDLE, then c1
    req_c0 = 1'b0; req_c1 = 1'b1;
    step();
    chk("turn_gnt", 32'({gnt_c1, gnt_c0}), 32'd0);
    chk("turn_cnt", 32'(strb_cnt), 32'd0);
    step();
    chk("idle_gnt_c1", 32'(gnt_c1), 32'd0);
    step();
    chk("handoff_gnt_c1", 32'(gnt_c1), 32'd1);

    // Reset drops the grant; tie out of reset goes to c0
    rst = 1'b0; req_c0 = 1'b1; req_c1 = 1'b1;
    step();
    chk("rst_drop_gnt_c1", 32'(gnt_c1), 32'd0);
    rst = 1'b1;
    step();
    chk("tie_gnt", 32'({gnt_c1, gnt_c0}), 32'd1);
    req_c0 = 1'b0;
    repeat (3) step();
    chk("fair_gnt_c1", 32'({gnt_c1, gnt_c0}), 32'd2);

    // Burst limit on c1: the 33rd strobe is blocked
    Address_c1 = 16'h0BEE;
    for (int i = 0; i < 33; i++) begin
      mstrb_c1 = 1'b1;
      #1;
      chk("burst_strobe", 32'(mstrb_sdram), (i < 32) ? 32'd1 : 32'd0);
      if (i == 32) chk("burst_err_before", 32'(err_c1), 32'd0);
      step();
    end
    mstrb_c1 = 1'b0;
    #1;
    chk("burst_err_c1", 32'(err_c1), 32'd1);
    chk("burst_cnt_sat", 32'(strb_cnt), 32'd32);
    chk("burst_err_c0", 32'(err_c0), 32'd0);
    repeat (3) step();
    chk("burst_err_sticky", 32'(err_c1), 32'd1);

    // c1 releases, drops and re-raises in TURN while c0 waits: c0 wins
    req_c1 = 1'b0; req_c0 = 1'b1;
    step();
    req_c1 = 1'b1;
    step();
    step();
    chk("rr_gnt", 32'({gnt_c1, gnt_c0}), 32'd1);

    // Reset mid-burst after 10 strobes from c0
    req_c1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      mstrb_c0 = 1'b1;
      step();
    end
    chk("mid_cnt", 32'(strb_cnt), 32'd10);
    rst = 1'b0;
    step();
    chk("mid_gnt_c0", 32'(gnt_c0), 32'd0);
    chk("mid_cnt_clr", 32'(strb_cnt), 32'd0);
    chk("mid_mstrb", 32'(mstrb_sdram), 32'd0);
    chk("mid_addr", 32'(Address_sdram), 32'd0);
    rst = 1'b1; mstrb_c0 = 1'b0; req_c0 = 1'b0;
    step();

    // Random traffic, checked by the model on every cycle
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) != 0);
      if (req_c0) req_c0 = ($urandom_range(0, 19) != 0);
      else        req_c0 = ($urandom_range(0, 7) == 0);
      if (req_c1) req_c1 = ($urandom_range(0, 19) != 0);
      else        req_c1 = ($urandom_range(0, 7) == 0);
      mstrb_c0 = gnt_c0 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
      mstrb_c1 = gnt_c1 ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 199) == 0);
      Address_c0 = AW'($urandom); Address_c1 = AW'($urandom);
      wr_rd_c0 = 1'($urandom); wr_rd_c1 = 1'($urandom);
      din_sdram_c0 = DW'($urandom); din_sdram_c1 = DW'($urandom);
      DOut_sdram = DW'($urandom);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
